// File: rtl/ppe_multi.sv
// Partial-sum PE: holds a NUM_FILTERS x FILTER_SIZE weight bank, slides every filter across
// each 1-bit ifmap row, streams one result packet per window, then requests the next row.
module ppe_multi #(
    parameter int FILTER_SIZE  = 5,
    parameter int IFMAP_SIZE   = 25,
    parameter int NUM_FILTERS  = 2,
    parameter int WEIGHT_W     = 8,
    parameter int ADDR_W       = 4,
    parameter int DATA_W       = 25,
    parameter int DEST_BASE    = 0,
    parameter int NUM_DEST     = 5,
    parameter int IFMAP_MEM_ID = 10,
    localparam int PKT_W       = ADDR_W + 1 + DATA_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PKT_W-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [PKT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             weights_loaded,
    output logic             drop_err
);
    localparam int OUT_DIM = IFMAP_SIZE - FILTER_SIZE + 1;
    localparam int WPP     = DATA_W / WEIGHT_W;
    localparam int SUM_W   = WEIGHT_W + $clog2(FILTER_SIZE) + 1;
    localparam int FIDX_W  = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
    localparam int NW      = NUM_FILTERS * FILTER_SIZE;
    localparam int PTR_W   = $clog2(NW + WPP + 1);
    localparam int J_W     = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    localparam int D_W     = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;

    typedef enum logic [1:0] {LOAD, RUN, REQ} state_t;
    state_t state, state_nxt;

    logic [WEIGHT_W-1:0]   w    [NW];
    logic [WEIGHT_W-1:0]   wnew [NW];
    logic [NW-1:0]         wen;
    logic [PTR_W-1:0]      wptr, wbase;
    logic [IFMAP_SIZE-1:0] row, src_row, win;
    logic [FIDX_W-1:0]     f, nf;
    logic [J_W-1:0]        j, nj;
    logic [D_W-1:0]        dcnt, ndc;
    logic [WEIGHT_W-1:0]   wsel [FILTER_SIZE];
    logic signed [SUM_W-1:0] acc;
    logic [DATA_W-1:0]     sext;
    logic [PKT_W-1:0]      res_pkt;
    logic wr_go, drop, start, step, go_req, fin, last, hs_out, opcode;
    logic unused_dest;

    assign unused_dest = ^in_data[PKT_W-1 -: ADDR_W];
    assign opcode      = in_data[DATA_W];
    assign hs_out      = out_valid & out_ready;
    assign last        = (f == FIDX_W'(NUM_FILTERS - 1)) && (j == J_W'(OUT_DIM - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= LOAD;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        wr_go     = 1'b0;
        drop      = 1'b0;
        start     = 1'b0;
        step      = 1'b0;
        go_req    = 1'b0;
        fin       = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (!opcode)            wr_go = 1'b1;
                    else if (weights_loaded) begin
                        start     = 1'b1;
                        state_nxt = RUN;
                    end else                drop  = 1'b1;
                end
            end
            RUN: if (hs_out) begin
                if (last) begin
                    go_req    = 1'b1;
                    state_nxt = REQ;
                end else step = 1'b1;
            end
            REQ: if (hs_out) begin
                fin       = 1'b1;
                state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    // Indices of the packet that will be presented after this edge; a new row starts at (0,0).
    always_comb begin
        src_row = row;
        nf      = f;
        nj      = j;
        ndc     = (dcnt == D_W'(NUM_DEST - 1)) ? '0 : dcnt + 1'b1;
        if (state == LOAD) begin
            src_row = in_data[IFMAP_SIZE-1:0];
            nf      = '0;
            nj      = '0;
            ndc     = '0;
        end else if (j == J_W'(OUT_DIM - 1)) begin
            nj = '0;
            nf = f + 1'b1;
        end else begin
            nj = j + 1'b1;
        end
    end

    always_comb begin
        win = src_row >> nj;
        acc = '0;
        for (int i = 0; i < FILTER_SIZE; i++) begin
            wsel[i] = w[i];
            for (int fi = 1; fi < NUM_FILTERS; fi++)
                if (nf == FIDX_W'(fi)) wsel[i] = w[fi*FILTER_SIZE + i];
            if (win[i]) acc = acc + SUM_W'(signed'(wsel[i]));
        end
        sext    = DATA_W'(acc);
        res_pkt = {ADDR_W'(DEST_BASE) + ADDR_W'(ndc), 1'b0, nf, sext[DATA_W-FIDX_W-1:0]};
    end

    // A weight packet arriving on a full bank restarts filling from slot 0.
    always_comb begin
        wbase = weights_loaded ? '0 : wptr;
        for (int s = 0; s < NW; s++) begin
            wen[s]  = 1'b0;
            wnew[s] = '0;
            for (int k = 0; k < WPP; k++)
                if (s == int'(wbase) + k) begin
                    wen[s]  = wr_go;
                    wnew[s] = in_data[k*WEIGHT_W +: WEIGHT_W];
                end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NW; s++) w[s] <= '0;
            wptr           <= '0;
            weights_loaded <= 1'b0;
            drop_err       <= 1'b0;
            row            <= '0;
            f              <= '0;
            j              <= '0;
            dcnt           <= '0;
            out_valid      <= 1'b0;
            out_data       <= '0;
        end else begin
            if (wr_go) begin
                for (int s = 0; s < NW; s++)
                    if (wen[s]) w[s] <= wnew[s];
                if (int'(wbase) + WPP >= NW) begin
                    weights_loaded <= 1'b1;
                    wptr           <= '0;
                end else begin
                    weights_loaded <= 1'b0;
                    wptr           <= wbase + PTR_W'(WPP);
                end
            end
            if (drop) drop_err <= 1'b1;
            if (start || step) begin
                row       <= src_row;
                f         <= nf;
                j         <= nj;
                dcnt      <= ndc;
                out_data  <= res_pkt;
                out_valid <= 1'b1;
            end
            if (go_req) out_data <= {ADDR_W'(IFMAP_MEM_ID), {(DATA_W+1){1'b0}}};
            if (fin) begin
                out_valid <= 1'b0;
                out_data  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_ppe_multi.sv
// Directed + randomized bench for ppe_multi against a window-sum reference model.
module tb_ppe_multi;
    localparam int FS = 5, IS = 25, NF = 2, WW = 8, AW = 4, DW = 25;
    localparam int DB = 0, ND = 5, MEM = 10;
    localparam int PKT_W = AW + 1 + DW, OUT_DIM = IS - FS + 1, WPP = DW / WW;
    localparam int NW = NF * FS, FIDX_W = 1;

    logic clk = 1'b0;
    logic reset;
    logic [PKT_W-1:0] in_data, out_data;
    logic in_valid, in_ready, out_valid, out_ready, weights_loaded, drop_err;

    int checks = 0, failures = 0;
    int wt [NW];
    logic [PKT_W-1:0] expq [$];
    logic [IS-1:0] ones;

    ppe_multi dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .weights_loaded(weights_loaded), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [PKT_W-1:0] pk);
        @(negedge clk);
        check("in_ready before send", in_ready, 1);
        in_data  = pk;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Weight packet p carries slots p*WPP.. in filter-major order; unused slots get junk.
    task automatic send_wpkt(input int p);
        logic [PKT_W-1:0] pk;
        pk = '0;
        pk[DW-1:0] = DW'($urandom);
        for (int k = 0; k < WPP; k++)
            if (p*WPP + k < NW) pk[k*WW +: WW] = WW'(wt[p*WPP + k]);
        send(pk);
    endtask

    task automatic load_all();
        for (int p = 0; p*WPP < NW; p++) send_wpkt(p);
    endtask

    task automatic build_exp(input logic [IS-1:0] r);
        expq.delete();
        for (int f = 0; f < NF; f++)
            for (int j = 0; j < OUT_DIM; j++) begin
                int s;
                int dest;
                longint data;
                s = 0;
                for (int i = 0; i < FS; i++)
                    if (((r >> (j + i)) & 25'd1) != 0) s += wt[f*FS + i];
                dest = DB + ((f*OUT_DIM + j) % ND);
                data = (longint'(s) & ((64'd1 << (DW - FIDX_W)) - 1)) |
                       (longint'(f) << (DW - FIDX_W));
                expq.push_back({AW'(dest), 1'b0, DW'(data)});
            end
        expq.push_back({AW'(MEM), 1'b0, DW'(0)});
    endtask

    task automatic run_row(input logic [IS-1:0] r, input bit rnd, input int stop_n);
        int got, cyc, total;
        bit stall;
        logic [PKT_W-1:0] prev;
        got = 0; cyc = 0; stall = 0; prev = '0;
        build_exp(r);
        total = expq.size();
        send({AW'(0), 1'b1, DW'(r)});
        check("first result latency", out_valid, 1);
        while (got < total && got != stop_n && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (stall) begin
                check("hold valid", out_valid, 1);
                check("hold data", out_data, prev);
            end
            out_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (out_valid && out_ready) begin
                check($sformatf("pkt%0d", got), out_data, expq[got]);
                got++;
            end
            stall = out_valid && !out_ready;
            prev  = out_data;
        end
        if (got < total && got != stop_n) check("row timeout", got, total);
        @(posedge clk);
        #1 out_ready = 1'b0;
        if (got == total) begin
            check("in_ready after row", in_ready, 1);
            check("out_valid after row", out_valid, 0);
            if (!rnd) check("stream cycles", cyc, total);
        end
    endtask

    task automatic set_default_wt();
        for (int i = 0; i < FS; i++) begin
            wt[i]      = i + 1;
            wt[FS + i] = -1;
        end
    endtask

    initial begin
        ones      = '1;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst in_ready", in_ready, 1);
        check("rst out_valid", out_valid, 0);
        check("rst out_data", out_data, 0);
        check("rst weights_loaded", weights_loaded, 0);
        check("rst drop_err", drop_err, 0);
        reset = 1'b0;

        // input before the bank is full is dropped
        set_default_wt();
        send_wpkt(0);
        send_wpkt(1);
        check("partial weights_loaded", weights_loaded, 0);
        send({AW'(0), 1'b1, DW'(ones)});
        check("drop_err set", drop_err, 1);
        @(negedge clk);
        check("drop no output", out_valid, 0);
        check("drop stays LOAD", in_ready, 1);
        send_wpkt(2);
        send_wpkt(3);
        check("weights_loaded", weights_loaded, 1);
        run_row(ones, 1'b0, -1);
        run_row(IS'(1), 1'b0, -1);
        for (int n = 0; n < 3; n++) run_row(IS'($urandom), 1'b1, -1);

        // reload with the most negative weight
        for (int s = 0; s < NW; s++) wt[s] = -128;
        send_wpkt(0);
        check("reload drops weights_loaded", weights_loaded, 0);
        for (int p = 1; p*WPP < NW; p++) send_wpkt(p);
        check("reload weights_loaded", weights_loaded, 1);
        run_row(ones, 1'b0, -1);

        // random weights and rows
        for (int s = 0; s < NW; s++) wt[s] = int'($urandom_range(0, 255)) - 128;
        load_all();
        for (int n = 0; n < 3; n++) run_row(IS'($urandom), 1'b1, -1);

        // reset in the middle of a row
        set_default_wt();
        load_all();
        run_row(ones, 1'b0, 7);
        reset = 1'b1;
        #1;
        check("midrst out_valid", out_valid, 0);
        check("midrst out_data", out_data, 0);
        check("midrst weights_loaded", weights_loaded, 0);
        check("midrst in_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        load_all();
        run_row(ones, 1'b0, -1);
        run_row(IS'($urandom), 1'b1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
